branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver.sv | 115 +++++++++++
 tb/tb_branch_resolver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// Resolves BEQ/BNE/J/JR one at a time: evaluate, redirect the PC, then flush fetch.
// Fixed latency: accept at N, pc_src at N+2, flush at N+3..N+4, idle at N+5.
module branch_resolver (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [15:0] instr_pc,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [15:0] prog_count,
    output logic        pc_src,
    output logic [15:0] pc_offset,
    output logic        flush,
    output logic        busy,
    output logic        misalign,
    output logic [15:0] taken_count,
    output logic [15:0] not_taken_count
);

    typedef enum logic [1:0] {IDLE, EVAL, REDIRECT, FLUSH} state_t;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FN_JR      = 6'b001000;

    state_t      state_q, state_d;
    logic [31:0] instr_q, rs_q, rt_q;
    logic [15:0] pc_q, target_q, target;
    logic        flush_cnt_q;
    logic        is_beq, is_bne, is_j, is_jr, taken, in_cf;
    logic        unused_bits;

    assign unused_bits = ^instr_q[25:16];

    assign in_cf = (instr[31:26] == OP_BEQ) || (instr[31:26] == OP_BNE) ||
                   (instr[31:26] == OP_J) ||
                   (instr[31:26] == OP_SPECIAL && instr[5:0] == FN_JR);

    assign is_beq = instr_q[31:26] == OP_BEQ;
    assign is_bne = instr_q[31:26] == OP_BNE;
    assign is_j   = instr_q[31:26] == OP_J;
    assign is_jr  = instr_q[31:26] == OP_SPECIAL && instr_q[5:0] == FN_JR;

    // Sign extension of the immediate is irrelevant once the sum is taken mod 2^16.
    always_comb begin
        taken  = 1'b0;
        target = pc_q + 16'd4 + {instr_q[13:0], 2'b00};
        if (is_beq) taken = (rs_q == rt_q);
        if (is_bne) taken = (rs_q != rt_q);
        if (is_j) begin
            taken  = 1'b1;
            target = {instr_q[13:0], 2'b00};
        end
        if (is_jr) begin
            taken  = 1'b1;
            target = rs_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (instr_valid && in_cf) state_d = EVAL;
            EVAL:     state_d = (taken && target[1:0] == 2'b00) ? REDIRECT : IDLE;
            REDIRECT: state_d = FLUSH;
            FLUSH:    if (flush_cnt_q) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            instr_q         <= '0;
            pc_q            <= '0;
            rs_q            <= '0;
            rt_q            <= '0;
            target_q        <= '0;
            flush_cnt_q     <= 1'b0;
            pc_src          <= 1'b0;
            flush           <= 1'b0;
            misalign        <= 1'b0;
            taken_count     <= '0;
            not_taken_count <= '0;
        end else begin
            state_q <= state_d;
            pc_src  <= (state_d == REDIRECT);
            flush   <= (state_d == FLUSH);
            if (state_q == IDLE && instr_valid && in_cf) begin
                instr_q <= instr;
                pc_q    <= instr_pc;
                rs_q    <= rs_data;
                rt_q    <= rt_data;
            end
            if (state_q == EVAL) begin
                target_q <= target;
                if (taken && target[1:0] != 2'b00)
                    misalign <= 1'b1;
                if (!taken && not_taken_count != 16'hFFFF)
                    not_taken_count <= not_taken_count + 16'd1;
            end
            if (state_q == REDIRECT && taken_count != 16'hFFFF)
                taken_count <= taken_count + 16'd1;
            flush_cnt_q <= (state_q == FLUSH);
        end
    end

    // Offset uses the live prog_count so the PC lands on target in the redirect cycle.
    assign pc_offset = pc_src ? (target_q - prog_count - 16'd4) : 16'h0000;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: timing, targets, counters, misalign and reset abort.
module tb_branch_resolver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [15:0] instr_pc = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic [15:0] prog_count = '0;
    logic        pc_src;
    logic [15:0] pc_offset;
    logic        flush;
    logic        busy;
    logic        misalign;
    logic [15:0] taken_count;
    logic [15:0] not_taken_count;

    int errors = 0;
    int checks = 0;
    int n_src, src_at, n_flush, flush_at, n_busy, idle_at;
    logic [15:0] src_off;

    branch_resolver dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .rs_data(rs_data), .rt_data(rt_data),
        .prog_count(prog_count), .pc_src(pc_src), .pc_offset(pc_offset),
        .flush(flush), .busy(busy), .misalign(misalign),
        .taken_count(taken_count), .not_taken_count(not_taken_count)
    );

    always #5 clock = ~clock;

    task automatic issue(input logic [31:0] i, input logic [15:0] pc,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] pcnt);
        @(negedge clock);
        instr = i; instr_pc = pc; rs_data = rs; rt_data = rt; prog_count = pcnt;
        instr_valid = 1'b1;
    endtask

    // Samples cycles N+1..N+n after acceptance; valid is held through cycle N+hold-1.
    task automatic observe(input int n, input int hold);
        n_src = 0; src_at = 0; src_off = '0; n_flush = 0; flush_at = 0; n_busy = 0; idle_at = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            if (i == 1 && hold > 1) begin
                instr = 32'h0800_0080; rs_data = 32'h9; rt_data = 32'h3;
            end
            if (i >= hold) instr_valid = 1'b0;
            if (pc_src) begin
                n_src++;
                if (src_at == 0) begin src_at = i; src_off = pc_offset; end
            end
            if (flush) begin
                n_flush++;
                if (flush_at == 0) flush_at = i;
            end
            if (busy) n_busy++;
            else if (idle_at == 0) idle_at = i;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL reset_pc_src got %b want 0", pc_src); end
        checks++; if (pc_offset !== 16'h0) begin errors++; $display("FAIL reset_pc_offset got %h want 0000", pc_offset); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", flush); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign); end
        checks++; if (taken_count !== 16'h0 || not_taken_count !== 16'h0) begin
            errors++; $display("FAIL reset_counts got %h/%h want 0000/0000", taken_count, not_taken_count); end
        reset = 1'b0;
    endtask

    task automatic test_beq_forward;
        issue(32'h1022_0003, 16'h0010, 32'h5, 32'h5, 16'h0018);
        observe(6, 1);
        checks++; if (n_src !== 1 || src_at !== 2) begin errors++; $display("FAIL beq_fwd_pc_src got n=%0d at=%0d want n=1 at=2", n_src, src_at); end
        checks++; if (src_off !== 16'h0004) begin errors++; $display("FAIL beq_fwd_offset got %h want 0004", src_off); end
        checks++; if (n_flush !== 2 || flush_at !== 3) begin errors++; $display("FAIL beq_fwd_flush got n=%0d at=%0d want n=2 at=3", n_flush, flush_at); end
        checks++; if (idle_at !== 5) begin errors++; $display("FAIL beq_fwd_idle got %0d want 5", idle_at); end
        checks++; if (taken_count !== 16'd1) begin errors++; $display("FAIL beq_fwd_taken got %0d want 1", taken_count); end
    endtask

    task automatic test_bne_backward;
        issue(32'h1422_FFFC, 16'h0040, 32'h1, 32'h2, 16'h004C);
        observe(6, 1);
        checks++; if (n_src !== 1 || src_off !== 16'hFFE4) begin errors++; $display("FAIL bne_back_offset got n=%0d off=%h want n=1 off=ffe4", n_src, src_off); end
        checks++; if (taken_count !== 16'd2) begin errors++; $display("FAIL bne_back_taken got %0d want 2", taken_count); end
    endtask

    task automatic test_beq_not_taken;
        issue(32'h1022_0003, 16'h0010, 32'h1, 32'h2, 16'h0018);
        observe(6, 1);
        checks++; if (n_src !== 0 || n_flush !== 0) begin errors++; $display("FAIL beq_nt_pulses got src=%0d flush=%0d want 0/0", n_src, n_flush); end
        checks++; if (n_busy !== 1 || idle_at !== 2) begin errors++; $display("FAIL beq_nt_busy got n=%0d idle=%0d want 1/2", n_busy, idle_at); end
        checks++; if (not_taken_count !== 16'd1 || taken_count !== 16'd2) begin
            errors++; $display("FAIL beq_nt_counts got nt=%0d t=%0d want 1/2", not_taken_count, taken_count); end
    endtask

    task automatic test_non_cf;
        issue(32'h0022_1820, 16'h0020, 32'h1, 32'h1, 16'h0024);
        observe(4, 1);
        checks++; if (n_busy !== 0 || n_src !== 0) begin errors++; $display("FAIL non_cf got busy=%0d src=%0d want 0/0", n_busy, n_src); end
    endtask

    task automatic test_jr_misalign;
        issue(32'h03E0_0008, 16'h0030, 32'h0000_0102, 32'h0, 16'h0034);
        observe(6, 1);
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL jr_misalign_flag got %b want 1", misalign); end
        checks++; if (n_src !== 0 || n_flush !== 0 || n_busy !== 1) begin
            errors++; $display("FAIL jr_misalign_pulses got src=%0d flush=%0d busy=%0d want 0/0/1", n_src, n_flush, n_busy); end
        issue(32'h0800_0040, 16'h0050, 32'h0, 32'h0, 16'h00F0);
        observe(6, 1);
        checks++; if (n_src !== 1 || src_off !== 16'h000C) begin errors++; $display("FAIL j_after_misalign got n=%0d off=%h want 1/000c", n_src, src_off); end
        checks++; if (misalign !== 1'b1 || taken_count !== 16'd3) begin
            errors++; $display("FAIL misalign_sticky got m=%b t=%0d want 1/3", misalign, taken_count); end
    endtask

    task automatic test_ignored_input;
        issue(32'h1000_0010, 16'h0080, 32'h7, 32'h7, 16'h0090);
        observe(7, 4);
        checks++; if (n_src !== 1 || src_off !== 16'h0030) begin errors++; $display("FAIL ignored_offset got n=%0d off=%h want 1/0030", n_src, src_off); end
        checks++; if (n_busy !== 4 || taken_count !== 16'd4) begin
            errors++; $display("FAIL ignored_busy got busy=%0d t=%0d want 4/4", n_busy, taken_count); end
    endtask

    task automatic test_reset_mid_flush;
        issue(32'h0800_0040, 16'h0050, 32'h0, 32'h0, 16'h00F0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            if (i == 1) instr_valid = 1'b0;
        end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mid_flush_pre got %b want 1", flush); end
        #1 reset = 1'b1;
        #1;
        checks++; if (flush !== 1'b0 || pc_src !== 1'b0 || pc_offset !== 16'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_flush_outputs got f=%b s=%b o=%h b=%b want 0/0/0000/0", flush, pc_src, pc_offset, busy); end
        checks++; if (taken_count !== 16'h0 || not_taken_count !== 16'h0 || misalign !== 1'b0) begin
            errors++; $display("FAIL mid_flush_state got t=%h nt=%h m=%b want 0/0/0", taken_count, not_taken_count, misalign); end
        @(negedge clock);
        reset = 1'b0;
        observe(5, 1);
        checks++; if (n_src !== 0 || n_flush !== 0 || n_busy !== 0) begin
            errors++; $display("FAIL mid_flush_after got src=%0d flush=%0d busy=%0d want 0/0/0", n_src, n_flush, n_busy); end
    endtask

    task automatic test_reset_eval_then_accept;
        issue(32'h0800_0040, 16'h0050, 32'h0, 32'h0, 16'h00F0);
        @(negedge clock);
        instr_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || pc_src !== 1'b0) begin errors++; $display("FAIL eval_reset got b=%b s=%b want 0/0", busy, pc_src); end
        @(negedge clock);
        reset = 1'b0;
        instr = 32'h0800_0010; instr_pc = 16'h0010; prog_count = 16'h0020; instr_valid = 1'b1;
        observe(6, 1);
        checks++; if (n_src !== 1 || src_at !== 2 || src_off !== 16'h001C) begin
            errors++; $display("FAIL accept_after_reset got n=%0d at=%0d off=%h want 1/2/001c", n_src, src_at, src_off); end
        checks++; if (taken_count !== 16'd1 || not_taken_count !== 16'd0) begin
            errors++; $display("FAIL accept_after_reset_counts got t=%0d nt=%0d want 1/0", taken_count, not_taken_count); end
    endtask

    task automatic test_saturation;
        @(negedge clock);
        force dut.taken_count = 16'hFFFE;
        @(negedge clock);
        release dut.taken_count;
        issue(32'h0800_0040, 16'h0050, 32'h0, 32'h0, 16'h00F0);
        observe(6, 1);
        checks++; if (taken_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h want ffff", taken_count); end
        issue(32'h0800_0040, 16'h0050, 32'h0, 32'h0, 16'h00F0);
        observe(6, 1);
        checks++; if (taken_count !== 16'hFFFF || n_src !== 1) begin
            errors++; $display("FAIL sat_hold got %h src=%0d want ffff/1", taken_count, n_src); end
    endtask

    initial begin
        test_reset;
        test_beq_forward;
        test_bne_backward;
        test_beq_not_taken;
        test_non_cf;
        test_jr_misalign;
        test_ignored_input;
        test_reset_mid_flush;
        test_reset_eval_then_accept;
        test_saturation;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
